// File: rtl/cache_tag_lookup_ctrl.sv
// rtl/cache_tag_lookup_ctrl.sv - tag lookup / miss fill control in front of the tag RAM.
// Optional hit/miss statistics counters are enabled by defining CACHE_STATS_EN.
module cache_tag_lookup_ctrl #(
  parameter int TAG_W   = 8,
  parameter int INDEX_W = 6
`ifdef CACHE_STATS_EN
  ,
  parameter int STAT_W  = 16
`endif
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       CpuReq,
  input  logic [TAG_W+INDEX_W-1:0]   CpuAddr,
  output logic                       CpuAck,
  output logic                       CpuHit,
  output logic                       Busy,
  output logic [INDEX_W-1:0]         TagAddr,
  output logic [TAG_W-1:0]           TagIn,
  input  logic [TAG_W-1:0]           TagOut,
  output logic                       TagWrite,
  output logic                       MemReq,
  output logic [TAG_W+INDEX_W-1:0]   MemAddr,
  input  logic                       MemAck
`ifdef CACHE_STATS_EN
  ,
  output logic [STAT_W-1:0]          HitCount,
  output logic [STAT_W-1:0]          MissCount
`endif
);

  localparam int ADDR_W = TAG_W + INDEX_W;
  localparam int LINES  = 2 ** INDEX_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    COMPARE = 3'd2,
    FETCH   = 3'd3,
    UPDATE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [INDEX_W-1:0]  tag_addr_q, tag_addr_d;
  logic [TAG_W-1:0]    tag_in_q, tag_in_d;
  logic                tag_write_q, tag_write_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic                lookup_hit;

  assign req_tag    = req_addr_q[ADDR_W-1:INDEX_W];
  assign req_index  = req_addr_q[INDEX_W-1:0];
  // TagOut is only meaningful in COMPARE, one posedge after the RAM sampled TagAddr.
  assign lookup_hit = valid_q[req_index] && (TagOut == req_tag);

`ifdef CACHE_STATS_EN
  logic [STAT_W-1:0] hit_count_q, hit_count_d;
  logic [STAT_W-1:0] miss_count_q, miss_count_d;
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
`endif

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    valid_d     = valid_q;
    tag_addr_d  = tag_addr_q;
    tag_in_d    = tag_in_q;
    tag_write_d = 1'b0;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
`ifdef CACHE_STATS_EN
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (CpuReq) begin
          req_addr_d = CpuAddr;
          tag_addr_d = CpuAddr[INDEX_W-1:0];
          state_d    = READ;
        end
      end

      READ: begin
        state_d = COMPARE;
      end

      COMPARE: begin
        if (lookup_hit) begin
          state_d = IDLE;
`ifdef CACHE_STATS_EN
          if (hit_count_q != '1) hit_count_d = hit_count_q + STAT_ONE;
`endif
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = req_addr_q;
          state_d    = FETCH;
`ifdef CACHE_STATS_EN
          if (miss_count_q != '1) miss_count_d = miss_count_q + STAT_ONE;
`endif
        end
      end

      FETCH: begin
        if (MemAck) begin
          mem_req_d   = 1'b0;
          tag_in_d    = req_tag;
          tag_write_d = 1'b1;
          state_d     = UPDATE;
        end
      end

      UPDATE: begin
        // The RAM has already committed the tag at this cycle's negedge.
        valid_d[req_index] = 1'b1;
        state_d            = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      valid_q     <= '0;
      tag_addr_q  <= '0;
      tag_in_q    <= '0;
      tag_write_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
`ifdef CACHE_STATS_EN
      hit_count_q  <= '0;
      miss_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      valid_q     <= valid_d;
      tag_addr_q  <= tag_addr_d;
      tag_in_q    <= tag_in_d;
      tag_write_q <= tag_write_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
`ifdef CACHE_STATS_EN
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
`endif
    end
  end

  // A hit must be acknowledged in the same cycle TagOut arrives, so the ack is decoded from state.
  assign CpuAck   = ((state_q == COMPARE) && lookup_hit) || (state_q == UPDATE);
  assign CpuHit   = (state_q == COMPARE) && lookup_hit;
  assign Busy     = (state_q != IDLE);
  assign TagAddr  = tag_addr_q;
  assign TagIn    = tag_in_q;
  assign TagWrite = tag_write_q;
  assign MemReq   = mem_req_q;
  assign MemAddr  = mem_addr_q;

`ifdef CACHE_STATS_EN
  assign HitCount  = hit_count_q;
  assign MissCount = miss_count_q;
`endif

endmodule
